step_counter: RTL

STEP_COUNTER -- requirements
Module: step_counter

---
 rtl/step_counter_pkg.sv | 11 +
 rtl/step_counter_next.sv | 49 ++++
 rtl/step_counter.sv | 88 ++++++++
 3 files changed

// File: rtl/step_counter_pkg.sv
// Shared types and constants for the step counter block.
package step_counter_pkg;

    typedef enum logic {
        MODE_WRAP     = 1'b0,
        MODE_SATURATE = 1'b1
    } mode_e;

    localparam int TALLY_W = 16;

endpackage

// File: rtl/step_counter_next.sv
// Combinational next-value arithmetic for the step counter: one up/down step
// with wrap or saturate on crossing 0 / MAX_VALUE.
module step_counter_next
    import step_counter_pkg::*;
#(
    parameter  int MAX_VALUE = 255,
    localparam int W         = $clog2(MAX_VALUE + 1)
) (
    input  logic [W-1:0] count,
    input  logic [W-1:0] step,
    input  logic         dir,
    input  mode_e        mode,
    output logic [W-1:0] next,
    output logic         crossed
);

    localparam logic [W-1:0] MAX_W     = W'(MAX_VALUE);
    localparam logic [W:0]   MAX_EXT   = (W+1)'(MAX_VALUE);
    localparam logic [W:0]   RANGE_EXT = (W+1)'(MAX_VALUE + 1);

    logic [W-1:0] step_eff;
    logic [W:0]   sum;
    logic [W:0]   diff_wrap;

    // One extra bit keeps the carry when MAX_VALUE+1 is a power of two.
    always_comb begin
        step_eff  = (step > MAX_W) ? MAX_W : step;
        sum       = {1'b0, count} + {1'b0, step_eff};
        diff_wrap = {1'b0, count} + RANGE_EXT - {1'b0, step_eff};
        next      = count;
        crossed   = 1'b0;
        if (!dir) begin
            if (sum > MAX_EXT) begin
                crossed = 1'b1;
                next    = (mode == MODE_SATURATE) ? MAX_W : W'(sum - RANGE_EXT);
            end else begin
                next = W'(sum);
            end
        end else begin
            if (step_eff > count) begin
                crossed = 1'b1;
                next    = (mode == MODE_SATURATE) ? '0 : W'(diff_wrap);
            end else begin
                next = count - step_eff;
            end
        end
    end

endmodule

// File: rtl/step_counter.sv
// Up/down step counter with clear/load/step priority, wrap pulse and limit decodes.
// Optional wrap pulse tally enabled by defining STEP_COUNTER_WRAP_TALLY_EN.
module step_counter
    import step_counter_pkg::*;
#(
    parameter  int    MAX_VALUE = 255,
    parameter  mode_e MODE      = MODE_WRAP,
    localparam int    W         = $clog2(MAX_VALUE + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic [W-1:0] step,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         at_max,
    output logic         at_zero
`ifdef STEP_COUNTER_WRAP_TALLY_EN
    ,
    output logic [TALLY_W-1:0] wrap_tally
`endif
);

    localparam logic [W-1:0] MAX_W = W'(MAX_VALUE);

    logic [W-1:0] step_next;
    logic         step_crossed;
    logic [W-1:0] count_d;
    logic         wrap_d;

    step_counter_next #(
        .MAX_VALUE (MAX_VALUE)
    ) u_next (
        .count   (count),
        .step    (step),
        .dir     (dir),
        .mode    (MODE),
        .next    (step_next),
        .crossed (step_crossed)
    );

    // Priority: clear over load over step; idle holds count and drops wrap.
    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_value > MAX_W) ? MAX_W : load_value;
        end else if (en) begin
            count_d = step_next;
            wrap_d  = step_crossed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_d;
            wrap  <= wrap_d;
        end
    end

    assign at_max  = (count == MAX_W);
    assign at_zero = (count == '0);

`ifdef STEP_COUNTER_WRAP_TALLY_EN
    // Tally advances alongside the wrap register and sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_tally <= '0;
        end else if (clear) begin
            wrap_tally <= '0;
        end else if (wrap_d && (wrap_tally != '1)) begin
            wrap_tally <= wrap_tally + 1'b1;
        end
    end
`else
    // Without the tally, wrap pulses are not accumulated.
`endif

endmodule
